// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state encoding, default busy latencies and small opcode classifiers.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || is_div_op(op);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MD datapath: returns the 64-bit {hi,lo} result of a
// mult/multu/div/divu, including divide-by-zero and signed-overflow cases.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [63:0] result_o
);

    logic        signed_div;
    logic        rs_neg;
    logic        rt_neg;
    logic        rt_zero;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] rt_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

    // Signed divide goes through magnitudes so truncation toward zero and the
    // remainder sign are explicit. 0x80000000 / -1 falls out as 0x80000000 rem 0
    // because its magnitude wraps back to the same bit pattern.
    assign signed_div = (op_i == MD_DIV);
    assign rs_neg     = signed_div & rs_i[31];
    assign rt_neg     = signed_div & rt_i[31];
    assign rs_mag     = rs_neg ? (32'd0 - rs_i) : rs_i;
    assign rt_mag     = rt_neg ? (32'd0 - rt_i) : rt_i;
    assign rt_zero    = (rt_i == 32'd0);
    assign rt_safe    = rt_zero ? 32'd1 : rt_mag;
    assign q_mag      = rs_mag / rt_safe;
    assign r_mag      = rs_mag % rt_safe;
    assign quot       = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem        = rs_neg ? (32'd0 - r_mag) : r_mag;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        result_o = 64'd0;
        case (md_op_e'(op_i))
            MD_MULT:  result_o = prod_s;
            MD_MULTU: result_o = prod_u;
            MD_DIV, MD_DIVU: begin
                if (rt_zero) result_o = {rs_i, 32'hFFFF_FFFF};
                else         result_o = {rem, quot};
            end
            default:  result_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MD sequencer owning HI/LO; models fixed mult/div latency and the
// D-stage MD stall. Build option MDU_DIV0_HOLD_EN: divide by zero leaves HI/LO.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op_E,
    input  logic        md_valid_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic        start,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e         state_q;
    logic [CNT_W-1:0]  count_q;
    logic [63:0]       pend_q;
    logic              hold_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;

    logic [63:0]       arith_res;
    logic              div0_hold;

    mdu_arith u_arith (
        .op_i     (md_op_E),
        .rs_i     (rs_E),
        .rt_i     (rt_E),
        .result_o (arith_res)
    );

`ifdef MDU_DIV0_HOLD_EN
    assign div0_hold = is_div_op(md_op_E) && (rt_E == 32'd0);
`else
    assign div0_hold = 1'b0;
`endif

    assign busy     = (state_q == ST_RUN);
    assign start    = md_valid_E & is_long_op(md_op_E) & ~busy;
    assign md_stall = md_use_D & (busy | start);
    assign hi       = hi_q;
    assign lo       = lo_q;

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pend_q  <= 64'd0;
            hold_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pend_q  <= arith_res;
                        hold_q  <= div0_hold;
                        count_q <= is_div_op(md_op_E) ? CNT_W'(DIV_CYCLES)
                                                      : CNT_W'(MULT_CYCLES);
                        state_q <= ST_RUN;
                    end else if (md_valid_E && (md_op_E == MD_MTHI)) begin
                        hi_q <= rs_E;
                    end else if (md_valid_E && (md_op_E == MD_MTLO)) begin
                        lo_q <= rs_E;
                    end
                end
                ST_RUN: begin
                    // Anything presented on md_op_E while running is ignored.
                    if (count_q == CNT_W'(1)) begin
                        if (!hold_q) begin
                            hi_q <= pend_q[63:32];
                            lo_q <= pend_q[31:0];
                        end
                        count_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
